alu_out_stage: RTL and testbench
================================

# alu_out_stage

Registered output stage directly downstream of the ALU (adder, logic unit, set-on-less-than comparator). It captures each ALU result with its write-back and memory-access controls, derives the zero flag, and presents the bundle to the memory stage over a valid/ready handshake. A 2-entry skid buffer gives full throughput with a fully registered `in_ready`. It also supports pipeline flush.

## Interface
- `DATA_W`, 32, ALU result and store-data width
- `REG_W`, 5, destination register index width

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  discard every held entry and the current input
- `in_valid`  in  1  ALU bundle valid
- `in_ready`  out  1  stage can accept; registered (`~skid_valid`)
- `in_result`  in  DATA_W  ALU result (SLT: bit 0 only, [31:1]=0)
- `in_store_data`  in  DATA_W  rt value for stores
- `in_rd`  in  REG_W  destination register
- `in_reg_write`, `in_mem_read`, `in_mem_write`  in  1 each  control bits
- `out_valid`  out  1  bundle valid to memory stage
- `out_ready`  in  1  memory stage accepts
- `out_result`, `out_store_data`  out  DATA_W  registered payload
- `out_rd`  out  REG_W
- `out_reg_write`, `out_mem_read`, `out_mem_write`  out  1 each
- `out_zero`  out  1  `out_result == 0`, computed at capture

## Operation
- Transfer in: `in_valid & in_ready` at a rising edge. Transfer out: `out_valid & out_ready`.
- Two payload registers: `main` drives the outputs; `skid` holds the overflow entry.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0): accept -> ONE.
  - ONE (1,0): accept and no drain -> FULL (input goes to skid). Accept and drain -> ONE (input goes to main). Drain only -> EMPTY. Neither -> ONE.
  - FULL (1,1): `in_ready`=0. Drain -> ONE (skid moves to main). No drain -> FULL.
  - (0,1) is illegal and never reachable.
- Ordering is strict FIFO. The skid entry always leaves after main.
- `out_zero` is stored with the entry and is not recomputed from the output register.
- `flush` has priority over accept and drain. On the next edge main_valid and skid_valid are 0. An input offered in the flush cycle is dropped, even if `in_ready`=1. Payload registers may hold stale data; only the valid bits are cleared.
- A simultaneous `flush` and output transfer counts as a transfer to the consumer. The stage still empties.
- `rst` clears both valid bits and all payload registers to 0. It overrides `flush`.

## Timing
- Reset values: `out_valid`=0, all `out_*` payload=0, `out_zero`=0, `in_ready`=1 (during and after reset).
- Latency: 1 cycle. An input accepted at edge N is on the outputs with `out_valid`=1 after edge N.
- Throughput: 1 transfer/cycle while `out_ready`=1.
- `in_ready` depends only on registered state. It has no combinational path from `out_ready` or `in_valid`.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.
- Back-pressure: at most 2 entries are held. `in_ready` falls on the edge that fills skid and rises on the edge that drains main.

## Structure
- Shared package `mcu_pkg` holds:
  - localparams `DATA_W`=32 and `REG_W`=5;
  - payload typedef `alu_out_t` with fields {result, store_data, rd, reg_write, mem_read, mem_write, zero}.
- One generic sub-module, `pipe_skid_buf`:
  - parameterised by payload width;
  - contains the valid/ready logic, the two registers and flush.
- The `alu_out_stage` top level packs inputs, computes zero, instantiates `pipe_skid_buf` and unpacks outputs.

## Test plan
- Reset check: hold `rst` 2 cycles with `in_valid`=1 -> `out_valid`=0, all outputs 0 and `in_ready`=1; the first accept occurs only after reset is released.
- Streaming: 8 SLT results (0/1 alternating, rd=1..8) with `out_ready`=1 -> same sequence out, 1-cycle latency, no bubbles, `out_zero` equals ~result[0].
- Back-pressure: send 0x00000005 then 0x00000000 with `out_ready`=0 -> `in_ready`=0 after the second edge; a third input is held off. Release `out_ready` -> 5 then 0 (`out_zero`=1), then the third input, in order.
- Flush in FULL: fill both entries, assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0 and `in_ready`=1; the flushed and offered entries never appear.
- Flush with a simultaneous drain: ONE state, `out_ready`=1, `flush`=1 -> the entry is consumed once and the stage is EMPTY after the edge.
- Control fields: store with `in_mem_write`=1, `in_store_data`=0xDEADBEEF, rd=0 -> the output carries identical fields and `out_reg_write`=0.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and widths for the execute/memory pipeline boundary.
// Holds the ALU output bundle layout and the skid-buffer occupancy encoding.
package mcu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              zero;
    } alu_out_t;

    // Occupancy encoded directly as {main_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_t;

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with registered in_ready and flush.
// The main register drives the outputs; skid catches the entry accepted while main stalls.
module pipe_skid_buf
    import mcu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_r;
    logic         skid_valid_r;
    logic [W-1:0] main_data_r;
    logic [W-1:0] skid_data_r;
    logic         accept_s;
    logic         drain_s;
    buf_state_t   state_s;

    assign state_s   = buf_state_t'({main_valid_r, skid_valid_r});
    assign accept_s  = in_valid & ~skid_valid_r;
    assign drain_s   = main_valid_r & out_ready;
    assign in_ready  = ~skid_valid_r;
    assign out_valid = main_valid_r;
    assign out_data  = main_data_r;

    // Occupancy and payload update; flush clears only the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_data_r  <= {W{1'b0}};
            skid_data_r  <= {W{1'b0}};
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            case (state_s)
                BUF_EMPTY: begin
                    if (accept_s) begin
                        main_valid_r <= 1'b1;
                        main_data_r  <= in_data;
                    end
                end
                BUF_ONE: begin
                    if (accept_s && !drain_s) begin
                        skid_valid_r <= 1'b1;
                        skid_data_r  <= in_data;
                    end else if (accept_s && drain_s) begin
                        main_data_r  <= in_data;
                    end else if (drain_s) begin
                        main_valid_r <= 1'b0;
                    end
                end
                BUF_FULL: begin
                    if (drain_s) begin
                        main_data_r  <= skid_data_r;
                        skid_valid_r <= 1'b0;
                    end
                end
                default: begin
                    main_valid_r <= 1'b0;
                    skid_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_out_stage.sv
// ALU output stage: bundles result and controls, derives zero at capture,
// and hands the bundle to the memory stage through a skid buffer.
module alu_out_stage
    import mcu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_zero
);

    alu_out_t in_bundle_s;
    alu_out_t out_bundle_s;

    // Pack the incoming bundle; zero travels with the entry.
    always_comb begin
        in_bundle_s.result     = in_result;
        in_bundle_s.store_data = in_store_data;
        in_bundle_s.rd         = in_rd;
        in_bundle_s.reg_write  = in_reg_write;
        in_bundle_s.mem_read   = in_mem_read;
        in_bundle_s.mem_write  = in_mem_write;
        in_bundle_s.zero       = is_zero(in_result);
    end

    pipe_skid_buf #(
        .W($bits(alu_out_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_bundle_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle_s)
    );

    assign out_result     = out_bundle_s.result;
    assign out_store_data = out_bundle_s.store_data;
    assign out_rd         = out_bundle_s.rd;
    assign out_reg_write  = out_bundle_s.reg_write;
    assign out_mem_read   = out_bundle_s.mem_read;
    assign out_mem_write  = out_bundle_s.mem_write;
    assign out_zero       = out_bundle_s.zero;

endmodule

// File: tb/tb_alu_out_stage.sv
// Scoreboard bench for alu_out_stage: a FIFO model of held entries is fed on
// accepted inputs and drained by a monitor comparing every presented output.
module tb_alu_out_stage;
    import mcu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_result = 32'h0;
    logic [DATA_W-1:0] in_store_data = 32'h0;
    logic [REG_W-1:0]  in_rd = 5'd0;
    logic              in_reg_write = 1'b0;
    logic              in_mem_read = 1'b0;
    logic              in_mem_write = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [DATA_W-1:0] out_store_data;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic              out_zero;

    int n_chk  = 0;
    int n_pass = 0;
    logic mon_en = 1'b0;
    alu_out_t sb[$];

    alu_out_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_store_data(in_store_data), .in_rd(in_rd),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic alu_out_t outputs_now();
        alu_out_t b;
        b.result     = out_result;
        b.store_data = out_store_data;
        b.rd         = out_rd;
        b.reg_write  = out_reg_write;
        b.mem_read   = out_mem_read;
        b.mem_write  = out_mem_write;
        b.zero       = out_zero;
        return b;
    endfunction

    function automatic alu_out_t inputs_now();
        alu_out_t b;
        b.result     = in_result;
        b.store_data = in_store_data;
        b.rd         = in_rd;
        b.reg_write  = in_reg_write;
        b.mem_read   = in_mem_read;
        b.mem_write  = in_mem_write;
        b.zero       = (in_result == 32'd0);
        return b;
    endfunction

    // Reference model: decides what the coming edge does to the set of held entries.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst || flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(inputs_now());
        end
    end

    // Monitor: at most two held entries, head presented and stable, popped on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready", {127'd0, in_ready}, {127'd0, sb.size() < 2});
                chk("out_valid", {127'd0, out_valid}, {127'd0, sb.size() != 0});
                if (out_valid && sb.size() != 0) begin
                    chk("bundle", {55'd0, outputs_now()}, {55'd0, sb[0]});
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] sd, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic mw);
        in_result = r; in_store_data = sd; in_rd = rd;
        in_reg_write = rw; in_mem_read = mr; in_mem_write = mw;
    endtask

    task automatic send(input logic [31:0] r, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
        logic acc;
        acc = 1'b0;
        drive(r, sd, rd, rw, mr, mw);
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            acc = in_ready;
            cyc();
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("send_accept", {127'd0, acc}, 128'd1);
    endtask

    initial begin
        // Reset with an input offered: nothing may be captured.
        drive(32'h1234_5678, 32'h9abc_def0, 5'd7, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b1;
        cyc();
        mon_en = 1'b1;
        cyc();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_payload", {55'd0, outputs_now()}, 128'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        cyc();

        // Streaming SLT results with no back-pressure.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send({31'd0, i[0]}, 32'h0, i[4:0], 1'b1, 1'b0, 1'b0);
        cyc();
        cyc();

        // Back-pressure: two entries fill the stage, a third waits.
        out_ready = 1'b0;
        send(32'h0000_0005, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        drive(32'h0000_0033, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        cyc(); cyc(); cyc();
        out_ready = 1'b1;
        send(32'h0000_0033, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
        cyc(); cyc(); cyc();

        // Flush while FULL with an input offered.
        out_ready = 1'b0;
        send(32'haaaa_0001, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0);
        send(32'haaaa_0002, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0);
        drive(32'haaaa_0003, 32'h0, 5'd14, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_valid", {127'd0, out_valid}, 128'd0);
        chk("flush_full_ready", {127'd0, in_ready}, 128'd1);
        cyc();

        // Flush coinciding with a drain from ONE.
        send(32'h0000_0bbb, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_drain_valid", {127'd0, out_valid}, 128'd0);
        cyc();

        // Store carrying control fields and store data.
        send(32'h0000_0100, 32'hdead_beef, 5'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("store_reg_write", {127'd0, out_reg_write}, 128'd0);
        cyc();

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), $urandom(),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cyc();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        chk("final_empty", {127'd0, out_valid}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
